// File: rtl/shift_register_piso_if.sv
// Load handshake and serial output bundle for shift_register_piso.
// Latency: none, wires only.
// Backpressure: load_ready flows back to the word source; shift_en is the consumer's stall.
//
// master: the upstream word source and serial consumer (drives load_valid, I, shift_en).
// slave : the shift register itself (drives load_ready, sout, sout_valid, busy, done).
interface shift_register_piso_if #(
  parameter int n = 8
) ();
  logic         load_valid;
  logic         load_ready;
  logic [n-1:0] I;
  logic         shift_en;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  modport master (
    output load_valid, I, shift_en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, I, shift_en,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/shift_register_piso.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake.
// Latency: a word loaded at edge k presents bit 0 right after edge k; done follows the last consumed bit by one cycle.
// Backpressure: shift_en=0 freezes the presented bit; a new word is accepted only in IDLE or on the last-bit edge.
//
// Ports: clk, reset_n (async active-low); bus (slave modport) carries load_valid/load_ready/I,
// shift_en, sout, sout_valid, busy and done.
module shift_register_piso #(
  parameter int n         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_register_piso_if.slave  bus
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [n-1:0]    shreg, shreg_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            done_q, done_nxt;

  logic            last_bit;
  logic            load;
  logic [n-1:0]    shreg_shifted;

  // The final bit leaves on this edge, which is also the only SHIFT-state
  // edge where a new word may be taken without an idle gap.
  assign last_bit = (state == SHIFT) && (count == LAST) && bus.shift_en;

  assign bus.load_ready = (state == IDLE) || last_bit;
  assign load           = bus.load_valid && bus.load_ready;

  // Move toward the output end, back-filling with zero.
  assign shreg_shifted = LSB_FIRST ? {1'b0, shreg[n-1:1]} : {shreg[n-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    done_nxt  = last_bit;

    if (load) begin
      // Covers both the IDLE load and the back-to-back load on the last-bit edge.
      state_nxt = SHIFT;
      shreg_nxt = bus.I;
      count_nxt = '0;
    end else if (state == SHIFT && bus.shift_en) begin
      shreg_nxt = shreg_shifted;
      if (last_bit) begin
        state_nxt = IDLE;
        count_nxt = '0;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  // All serial-side outputs come from registers only.
  assign bus.sout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) && (LSB_FIRST ? shreg[0] : shreg[n-1]);
  assign bus.done       = done_q;

endmodule
